// File: rtl/processor_pkg.sv
// Shared definitions for the simple processor: instruction width, default
// address width and the opcode field position used by fetch and decode.
package processor_pkg;

    localparam int INST_WIDTH     = 32;
    localparam int ADDR_WIDTH_DEF = 12;

    // Opcode field position inside an instruction word (shared with the decoder)
    localparam int OPCODE_MSB     = 31;
    localparam int OPCODE_LSB     = 27;

    // Instruction word type used on the fetch -> decode boundary
    typedef logic [INST_WIDTH-1:0] inst_word_t;

endpackage : processor_pkg

// File: rtl/instruction_fetch_fetch_hold_buffer.sv
// One-entry hold register that absorbs the ROM read latency while the
// decoder stalls, plus the output mux that presents either the held word
// or the word arriving from the ROM this cycle.
module fetch_hold_buffer
    import processor_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_pend,
    input  logic [INST_WIDTH-1:0] i_imem_q,
    input  logic [ADDR_WIDTH-1:0] i_pend_pc,
    input  logic                  i_inst_ready,
    input  logic                  i_flush,
    output logic                  o_hold_valid,
    output logic                  o_inst_valid,
    output logic [INST_WIDTH-1:0] o_inst,
    output logic [ADDR_WIDTH-1:0] o_inst_pc
);

    logic                  r_hold_valid;
    logic [INST_WIDTH-1:0] r_hold_inst;
    logic [ADDR_WIDTH-1:0] r_hold_pc;
    logic                  w_live;

    // Capture the arriving ROM word when the decoder stalls; drop it on accept or flush
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hold_valid <= 1'b0;
            r_hold_inst  <= {INST_WIDTH{1'b0}};
            r_hold_pc    <= {ADDR_WIDTH{1'b0}};
        end else if (i_flush) begin
            r_hold_valid <= 1'b0;
        end else if (i_inst_ready) begin
            r_hold_valid <= 1'b0;
        end else if (i_pend) begin
            r_hold_valid <= 1'b1;
            r_hold_inst  <= i_imem_q;
            r_hold_pc    <= i_pend_pc;
        end else begin
            r_hold_valid <= r_hold_valid;
        end
    end

    assign w_live       = (r_hold_valid | i_pend) & ~i_flush;
    assign o_hold_valid = r_hold_valid;
    assign o_inst_valid = w_live;

    // Output mux: held entry wins over the ROM word; zero when nothing is live
    always_comb begin
        o_inst    = {INST_WIDTH{1'b0}};
        o_inst_pc = {ADDR_WIDTH{1'b0}};
        if (w_live) begin
            if (r_hold_valid) begin
                o_inst    = r_hold_inst;
                o_inst_pc = r_hold_pc;
            end else begin
                o_inst    = i_imem_q;
                o_inst_pc = i_pend_pc;
            end
        end else begin
            o_inst    = {INST_WIDTH{1'b0}};
            o_inst_pc = {ADDR_WIDTH{1'b0}};
        end
    end

endmodule : fetch_hold_buffer

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the program counter, addresses the synchronous
// instruction ROM and hands instructions with their PC to the decoder
// under valid/ready. Redirects from execute squash in-flight fetches.
module instruction_fetch
    import processor_pkg::*;
#(
    parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = {ADDR_WIDTH{1'b0}}
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [INST_WIDTH-1:0] imem_q,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_target,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [INST_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic [ADDR_WIDTH-1:0] inst_pc_plus_1
);

    localparam logic [ADDR_WIDTH-1:0] PC_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic                  r_pend;
    logic [ADDR_WIDTH-1:0] r_pend_pc;
    logic                  w_hold_valid;
    logic                  w_issue;

    // A new ROM read is started unless a stalled word would be overwritten
    assign w_issue   = redirect_valid | inst_ready | (~w_hold_valid & ~r_pend);
    assign imem_addr = redirect_valid ? redirect_target : r_fetch_pc;

    // Program counter and in-flight read tracking; redirect overrides issue
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_pend     <= 1'b0;
            r_pend_pc  <= {ADDR_WIDTH{1'b0}};
        end else if (redirect_valid) begin
            r_pend     <= 1'b1;
            r_pend_pc  <= redirect_target;
            r_fetch_pc <= redirect_target + PC_ONE;
        end else if (w_issue) begin
            r_pend     <= 1'b1;
            r_pend_pc  <= r_fetch_pc;
            r_fetch_pc <= r_fetch_pc + PC_ONE;
        end else begin
            r_pend     <= 1'b0;
        end
    end

    fetch_hold_buffer #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_hold (
        .clock        (clock),
        .reset        (reset),
        .i_pend       (r_pend),
        .i_imem_q     (imem_q),
        .i_pend_pc    (r_pend_pc),
        .i_inst_ready (inst_ready),
        .i_flush      (redirect_valid),
        .o_hold_valid (w_hold_valid),
        .o_inst_valid (inst_valid),
        .o_inst       (inst),
        .o_inst_pc    (inst_pc)
    );

    // Link value wraps naturally at the address width
    assign inst_pc_plus_1 = inst_pc + PC_ONE;

endmodule : instruction_fetch

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    logic        clock;
    logic        reset;
    logic [11:0] imem_addr;
    logic [31:0] imem_q;
    logic        redirect_valid;
    logic [11:0] redirect_target;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [11:0] inst_pc;
    logic [11:0] inst_pc_plus_1;

    int n_cmp = 0;
    int n_err = 0;

    // Architectural model: next PC the decoder should see, and whether the
    // stream has started since reset
    logic        m_started;
    logic [11:0] m_pc;

    instruction_fetch #(
        .ADDR_WIDTH (12),
        .RESET_PC   (12'h000)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .imem_addr       (imem_addr),
        .imem_q          (imem_q),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .inst_pc_plus_1  (inst_pc_plus_1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] rom_word(input logic [11:0] a);
        return 32'h0000_0100 + {20'h0_0000, a};
    endfunction

    // Synchronous ROM: word for the address sampled at the previous edge
    always @(posedge clock) imem_q <= rom_word(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic rv, input logic [11:0] tgt, input logic rdy);
        logic        ev;
        logic [11:0] epc;
        @(posedge clock);
        #1;
        reset           = rst;
        redirect_valid  = rv;
        redirect_target = tgt;
        inst_ready      = rdy;
        @(negedge clock);
        ev  = !rst && m_started && !rv;
        epc = ev ? m_pc : 12'h000;
        chk("inst_valid", {31'h0, inst_valid}, {31'h0, ev});
        chk("inst", inst, ev ? rom_word(m_pc) : 32'h0);
        chk("inst_pc", {20'h0, inst_pc}, {20'h0, epc});
        chk("inst_pc_plus_1", {20'h0, inst_pc_plus_1}, {20'h0, epc + 12'h001});
        if (!rst && rv) chk("imem_addr", {20'h0, imem_addr}, {20'h0, tgt});
        chk("hold_pend_exclusive", {31'h0, dut.r_pend & dut.u_hold.r_hold_valid}, 32'h0);
        if (rst) begin
            m_started = 1'b0;
            m_pc      = 12'h000;
        end else if (rv) begin
            m_pc      = tgt;
            m_started = 1'b1;
        end else begin
            if (m_started && rdy) m_pc = m_pc + 12'h001;
            m_started = 1'b1;
        end
    endtask

    initial begin
        reset           = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = 12'h000;
        inst_ready      = 1'b1;
        m_started       = 1'b0;
        m_pc            = 12'h000;

        repeat (3) step(1'b1, 1'b0, 12'h000, 1'b1);
        chk("lit_reset_plus1", {20'h0, inst_pc_plus_1}, 32'h1);

        // Reset release and steady streaming
        step(1'b0, 1'b0, 12'h000, 1'b1);
        chk("lit_first_invalid", {31'h0, inst_valid}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 12'h000, 1'b1);
            chk("lit_stream_inst", inst, 32'h100 + i);
            chk("lit_stream_pc", {20'h0, inst_pc}, i);
            chk("lit_stream_pc1", {20'h0, inst_pc_plus_1}, i + 1);
        end

        // Stall at PC 3 for four cycles, then release
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 12'h000, 1'b0);
            chk("lit_stall_inst", inst, 32'h103);
            chk("lit_stall_pc", {20'h0, inst_pc}, 32'h3);
        end
        step(1'b0, 1'b0, 12'h000, 1'b1);
        chk("lit_release_inst", inst, 32'h103);
        step(1'b0, 1'b0, 12'h000, 1'b1);
        chk("lit_release_next", inst, 32'h104);

        // Redirect while PC 5 is presented
        step(1'b0, 1'b1, 12'h020, 1'b1);
        chk("lit_redirect_invalid", {31'h0, inst_valid}, 32'h0);
        step(1'b0, 1'b0, 12'h000, 1'b1);
        chk("lit_redirect_pc", {20'h0, inst_pc}, 32'h020);
        chk("lit_redirect_inst", inst, 32'h120);
        step(1'b0, 1'b0, 12'h000, 1'b1);
        chk("lit_after_redirect_pc", {20'h0, inst_pc}, 32'h021);

        // Redirect during a stall with the hold register full
        step(1'b0, 1'b0, 12'h000, 1'b0);
        step(1'b0, 1'b0, 12'h000, 1'b0);
        chk("lit_hold_full", {31'h0, dut.u_hold.r_hold_valid}, 32'h1);
        step(1'b0, 1'b1, 12'h040, 1'b0);
        step(1'b0, 1'b0, 12'h000, 1'b0);
        chk("lit_flush_pc", {20'h0, inst_pc}, 32'h040);
        chk("lit_flush_inst", inst, 32'h140);

        // Wrap from the top of the address space
        step(1'b0, 1'b1, 12'hFFF, 1'b1);
        step(1'b0, 1'b0, 12'h000, 1'b1);
        chk("lit_wrap_pc", {20'h0, inst_pc}, 32'hFFF);
        chk("lit_wrap_pc1", {20'h0, inst_pc_plus_1}, 32'h000);
        step(1'b0, 1'b0, 12'h000, 1'b1);
        chk("lit_wrap_next", {20'h0, inst_pc}, 32'h000);

        // Asynchronous reset between edges
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        chk("lit_async_reset", {31'h0, inst_valid}, 32'h0);
        m_started = 1'b0;
        m_pc      = 12'h000;
        repeat (2) step(1'b1, 1'b0, 12'h000, 1'b1);
        step(1'b0, 1'b0, 12'h000, 1'b1);
        chk("lit_restart_invalid", {31'h0, inst_valid}, 32'h0);
        step(1'b0, 1'b0, 12'h000, 1'b1);
        chk("lit_restart_pc", {20'h0, inst_pc}, 32'h000);
        chk("lit_restart_inst", inst, 32'h100);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic        r_rst;
            logic        r_rv;
            logic [11:0] r_tgt;
            logic        r_rdy;
            r_rst = ($urandom_range(0, 399) == 0);
            r_rv  = !r_rst && ($urandom_range(0, 7) == 0);
            r_tgt = 12'($urandom);
            r_rdy = ($urandom_range(0, 9) < 7);
            step(r_rst, r_rv, r_tgt, r_rdy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_instruction_fetch
